// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle for dmem_responder.
// master = pipeline side, slave = data memory responder.
interface dmem_responder_if;
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    modport master (
        output mem_en, mem_wr, funct3, addr, wdata,
        input  rdata, stall, fault
    );

    modport slave (
        input  mem_en, mem_wr, funct3, addr, wdata,
        output rdata, stall, fault
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: byte/half/word loads and stores with
// configurable wait states, alignment/illegal-op faulting and registered load data.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req_idle;
    logic            illegal;
    logic            misaligned;
    logic            accept;
    logic            enter_done;
    logic [AW+1:0]   rd_addr;
    logic [2:0]      rd_f3;
    logic            rd_wr;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wr_word;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:AW+2];

    // Request decode is only meaningful in IDLE; DONE still sees the same instruction.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.mem_wr) begin
            illegal = (bus.funct3 >= 3'b011);
        end else begin
            illegal = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                      (bus.funct3 == 3'b111);
        end
        if ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101)) begin
            misaligned = bus.addr[0];
        end else if (bus.funct3 == 3'b010) begin
            misaligned = (bus.addr[1:0] != 2'b00);
        end
        req_idle = rst_n && (state_q == IDLE) && bus.mem_en;
        accept   = req_idle && !illegal && !misaligned;
    end

    assign bus.fault = req_idle && (illegal || misaligned);
    assign bus.stall = accept || (rst_n && (state_q == WAIT));
    assign bus.rdata = rdata_q;

    // With zero wait states the load completes straight from IDLE, so read from the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            rd_addr = bus.addr[AW+1:0];
            rd_f3   = bus.funct3;
            rd_wr   = bus.mem_wr;
        end else begin
            rd_addr = addr_q;
            rd_f3   = funct3_q;
            rd_wr   = wr_q;
        end
        rd_word  = mem_q[rd_addr[AW+1:2]];
        rd_shift = rd_word >> {rd_addr[1:0], 3'b000};
        rd_half  = rd_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_f3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_val = {24'h000000, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'h0000, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = bus.addr[AW+1:0];
                    wdata_d  = bus.wdata;
                    funct3_d = bus.funct3;
                    wr_d     = bus.mem_wr;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_done && !rd_wr) begin
            rdata_d = load_val;
        end
    end

    always_comb begin
        we      = rst_n && (state_q == DONE) && wr_q;
        be      = 4'b1111;
        wr_word = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Array has no reset; a store lands on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr_q[AW+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: load/store sizes, faults, address wrap
// and reset abandonment, with hand-computed expected values.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request and holds it while stall is high; returns at the
    // negedge of the DONE cycle (or the faulting cycle) with mem_en dropped.
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int n, output logic f);
        @(negedge clk);
        bus.mem_en = 1'b1;
        bus.mem_wr = wr;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
        #1;
        f = bus.fault;
        n = 0;
        while (bus.stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        bus.mem_en = 1'b0;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] prev_rdata, input string tag);
        int   n;
        logic f;
        access(1'b1, f3, a, wd, n, f);
        chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
        chk({tag, "_fault"}, {31'd0, f}, 32'd0);
        chk({tag, "_rdata_kept"}, bus.rdata, prev_rdata);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
        int   n;
        logic f;
        access(1'b0, f3, a, 32'h0, n, f);
        chk({tag, "_stall_cycles"}, 32'(n), 32'd3);
        chk({tag, "_fault"}, {31'd0, f}, 32'd0);
        chk({tag, "_rdata"}, bus.rdata, exp);
    endtask

    task automatic flt(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] prev_rdata, input string tag);
        int   n;
        logic f;
        access(wr, f3, a, 32'hFFFF_FFFF, n, f);
        chk({tag, "_fault"}, {31'd0, f}, 32'd1);
        chk({tag, "_stall_cycles"}, 32'(n), 32'd0);
        chk({tag, "_rdata_kept"}, bus.rdata, prev_rdata);
        #1;
        chk({tag, "_fault_drop"}, {31'd0, bus.fault}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus.mem_en = 1'b1;
        bus.mem_wr = 1'b0;
        bus.funct3 = 3'b010;
        bus.addr   = 32'h0;
        bus.wdata  = 32'h0;
        #2;
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        bus.mem_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        st(3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, "sw10");
        ld(3'b010, 32'h10, 32'hDEAD_BEEF, "lw10");

        st(3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, "sw10_clr");
        st(3'b000, 32'h13, 32'h1234_5680, 32'hDEAD_BEEF, "sb13");
        ld(3'b000, 32'h13, 32'hFFFF_FF80, "lb13");
        ld(3'b100, 32'h13, 32'h0000_0080, "lbu13");
        ld(3'b010, 32'h10, 32'h8000_0000, "lw10_b");

        st(3'b010, 32'h20, 32'h0, 32'h8000_0000, "sw20_clr");
        st(3'b001, 32'h22, 32'hABCD_8001, 32'h8000_0000, "sh22");
        ld(3'b001, 32'h22, 32'hFFFF_8001, "lh22");
        ld(3'b101, 32'h22, 32'h0000_8001, "lhu22");
        ld(3'b010, 32'h20, 32'h8001_0000, "lw20");

        st(3'b010, 32'h40, 32'h1122_3344, 32'h8001_0000, "sw40");
        st(3'b000, 32'h41, 32'h0000_00AA, 32'h8001_0000, "sb41");
        ld(3'b010, 32'h40, 32'h1122_AA44, "lw40_a");
        st(3'b001, 32'h40, 32'h0000_5566, 32'h1122_AA44, "sh40");
        ld(3'b010, 32'h40, 32'h1122_5566, "lw40_b");
        ld(3'b000, 32'h42, 32'h0000_0022, "lb42");
        ld(3'b001, 32'h42, 32'h0000_1122, "lh42");

        st(3'b010, 32'h04, 32'hCAFE_F00D, 32'h0000_1122, "sw04");
        flt(1'b0, 3'b010, 32'h6, 32'h0000_1122, "lw06_mis");
        flt(1'b1, 3'b001, 32'h5, 32'h0000_1122, "sh05_mis");
        flt(1'b0, 3'b011, 32'h4, 32'h0000_1122, "ld011_ill");
        flt(1'b1, 3'b100, 32'h4, 32'h0000_1122, "st100_ill");
        flt(1'b0, 3'b110, 32'h4, 32'h0000_1122, "ld110_ill");
        ld(3'b010, 32'h04, 32'hCAFE_F00D, "lw04_kept");

        st(3'b010, 32'h0000_1008, 32'h1234_5678, 32'hCAFE_F00D, "sw_wrap");
        ld(3'b010, 32'h08, 32'h1234_5678, "lw_wrap");

        st(3'b010, 32'h30, 32'h1111_1111, 32'h1234_5678, "sw30");
        @(negedge clk);
        bus.mem_en = 1'b1;
        bus.mem_wr = 1'b1;
        bus.funct3 = 3'b010;
        bus.addr   = 32'h30;
        bus.wdata  = 32'hAAAA_AAAA;
        #1 chk("abort_stall_accept", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        chk("abort_stall_wait", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall_rst", {31'd0, bus.stall}, 32'd0);
        chk("abort_rdata_rst", bus.rdata, 32'h0);
        @(negedge clk);
        bus.mem_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ld(3'b010, 32'h30, 32'h1111_1111, "lw30_after_abort");

        @(negedge clk);
        chk("idle_stall", {31'd0, bus.stall}, 32'd0);
        chk("idle_fault", {31'd0, bus.fault}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states per access (0 allowed).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_en  input  1  memory-stage access request.
REQ-006 mem_wr  input  1  1 = store, 0 = load; valid when mem_en=1.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address from ALU result.
REQ-009 wdata  input  32  store data, rs2 value, LSB-aligned.
REQ-010 rdata  output  32  load result, sign/zero-extended, registered.
REQ-011 stall  output  1  holds pipeline while access is outstanding.
REQ-012 fault  output  1  misaligned or illegal access indication.

Function
REQ-013 FSM states IDLE, WAIT, DONE; a cycle counter of at least clog2(WAIT_CYCLES+1) bits.
REQ-014 IDLE, mem_en=1, access legal: capture addr, wdata, funct3 and mem_wr; load counter with WAIT_CYCLES-1 and go to WAIT, or go directly to DONE if WAIT_CYCLES=0.
REQ-015 WAIT: decrement the counter each cycle; go to DONE in the cycle after the counter reads 0.
REQ-016 DONE: always return to IDLE next cycle; mem_en is ignored in DONE because it carries the same instruction.
REQ-017 stall = (IDLE and mem_en and legal) or WAIT; stall is combinational and 0 in DONE.
REQ-018 Latency: an access accepted in cycle T has stall high in cycles T..T+WAIT_CYCLES and is in DONE at T+WAIT_CYCLES+1.
REQ-019 Word index = addr[clog2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-020 Byte lanes are little-endian: byte k of a word sits at data bits [8k+7:8k].
REQ-021 Load data is written into the rdata register on the clock edge entering DONE.
REQ-022 Load extension: LB sign-extends bit 7, LBU zero-extends; LH sign-extends bit 15, LHU zero-extends; LW has no extension.
REQ-023 rdata holds its value until the next load completes; stores never change rdata.
REQ-024 A store writes the array on the clock edge leaving DONE.
REQ-025 Store byte enables: SB writes 1 lane at addr[1:0] using wdata[7:0]; SH writes 2 lanes at addr[1] using wdata[15:0]; SW writes all 4 lanes.
REQ-026 Lanes whose byte enable is 0 keep their previous contents.
REQ-027 Misaligned access: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
REQ-028 Illegal access: load funct3 in {011, 110, 111}, or store funct3 >= 011.
REQ-029 fault = IDLE and mem_en and (misaligned or illegal); fault is combinational and high for exactly that cycle.
REQ-030 A faulting request stays in IDLE: no array access, no stall, rdata unchanged.
REQ-031 A load immediately following a store to the same word returns the newly stored data.
REQ-032 mem_en=0 in IDLE: state unchanged, stall=0, fault=0.

Reset
REQ-033 While rst_n=0: state=IDLE, counter=0, rdata=0, stall=0, fault=0.
REQ-034 Array contents are not reset.
REQ-035 Reset asserted in WAIT or DONE abandons the access; a pending store is not written.
REQ-036 First legal access is accepted in the first cycle with rst_n=1 and mem_en=1.

Verification
REQ-037 WAIT_CYCLES=2: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> stall high 3 cycles per access; rdata=0xDEADBEEF in load DONE.
REQ-038 SB 0x80 to addr 0x13 over word 0x00000000, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-039 SH 0x8001 to addr 0x22, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x80010000.
REQ-040 LW addr=0x6, SH addr=0x5, funct3=011 load -> fault=1 for one cycle each, stall=0, rdata and array unchanged.
REQ-041 SW addr=4*DEPTH_WORDS+8 wdata=0x12345678, then LW addr=0x8 -> rdata=0x12345678 (address wrap).
REQ-042 rst_n pulsed low in WAIT of SW 0x30=0xAAAAAAAA, after prior 0x30=0x11111111 -> stall=0 immediately, LW 0x30 -> 0x11111111.
